// File: rtl/sat_accumulator_pkg.sv
// Shared state encoding for the saturating batch accumulator.
package sat_acc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'b00;
  localparam state_t S_ACCUM = 2'b01;
  localparam state_t S_DONE  = 2'b10;

endpackage

// File: rtl/sat_accumulator_if.sv
// Operand-pair input stream and batch-result output stream of the accumulator.
interface sat_accumulator_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );

endinterface

// File: rtl/sat_accumulator_sat_add.sv
// Saturating unsigned adder: one extra carry bit detects overflow and clamps to all ones.
module sat_add #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] temp;

  assign temp = {1'b0, acc} + {1'b0, addend};
  assign sat  = temp[ACC_W];
  assign sum  = temp[ACC_W] ? {ACC_W{1'b1}} : temp[ACC_W-1:0];

endmodule

// File: rtl/sat_accumulator.sv
// Collects NUM_SAMPLES operand-pair sums into a saturating accumulator and
// hands the batch result downstream, flagging per-batch and sticky overflow.
module sat_accumulator
  import sat_acc_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int ACC_W       = 8,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  sat_accumulator_if.slave bus,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sat_reg, sat_next;
  logic             sticky_reg, sticky_next;
  logic             out_valid_reg, out_valid_next;

  logic [DATA_W:0]  pair_sum;
  logic [ACC_W-1:0] pair_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_sat;
  logic             ready;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;

  // Pair sum is formed one bit wider than the operands so it can never wrap.
  assign pair_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign pair_ext = ACC_W'(pair_sum);
  assign cnt_inc  = cnt_reg + CNT_W'(1);
  assign ready    = rst_n && !clear && (state_reg != S_DONE);
  assign accept   = bus.in_valid && ready;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc    (acc_reg),
    .addend (pair_ext),
    .sum    (add_sum),
    .sat    (add_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sat_reg       <= 1'b0;
      sticky_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      sat_reg       <= sat_next;
      sticky_reg    <= sticky_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    sat_next    = sat_reg;
    sticky_next = sticky_reg;
    if (clear) begin
      state_next  = S_IDLE;
      acc_next    = '0;
      cnt_next    = '0;
      sat_next    = 1'b0;
      sticky_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            acc_next   = pair_ext;
            cnt_next   = CNT_W'(1);
            state_next = (NUM_SAMPLES == 1) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_next = add_sum;
            cnt_next = cnt_inc;
            if (add_sat) begin
              sat_next    = 1'b1;
              sticky_next = 1'b1;
            end
            if (cnt_inc == LAST_CNT) begin
              state_next = S_DONE;
            end
          end
        end
        S_DONE: begin
          // Sticky overflow deliberately survives the result transfer.
          if (bus.out_ready) begin
            state_next = S_IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            sat_next   = 1'b0;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
    out_valid_next = (state_next == S_DONE);
  end

  always_comb begin
    bus.in_ready  = ready;
    bus.out_valid = out_valid_reg;
    bus.out_sum   = acc_reg;
    bus.out_sat   = sat_reg;
    ovf_sticky    = sticky_reg;
    sample_cnt    = cnt_reg;
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// Drives two accumulators (8-bit and 6-bit wide) in lockstep and checks
// batch results against a total-then-clamp scoreboard.
module tb_sat_accumulator;

  localparam int DATA_W = 4;
  localparam int NUM    = 4;
  localparam int CNT_W  = $clog2(NUM + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic out_ready = 1'b0;
  logic sticky8, sticky6;
  logic [CNT_W-1:0] cnt8, cnt6;

  int total = 0;
  int bad = 0;

  int sb[$];
  int m_total = 0;
  int m_cnt = 0;
  bit exp_sticky8 = 1'b0;
  bit exp_sticky6 = 1'b0;

  always #5 clk = ~clk;

  sat_accumulator_if #(.DATA_W(DATA_W), .ACC_W(8)) bus8 ();
  sat_accumulator_if #(.DATA_W(DATA_W), .ACC_W(6)) bus6 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.in_a      = in_a;
  assign bus8.in_b      = in_b;
  assign bus8.out_ready = out_ready;
  assign bus6.in_valid  = in_valid;
  assign bus6.in_a      = in_a;
  assign bus6.in_b      = in_b;
  assign bus6.out_ready = out_ready;

  sat_accumulator #(.DATA_W(DATA_W), .ACC_W(8), .NUM_SAMPLES(NUM)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus8),
    .ovf_sticky (sticky8),
    .sample_cnt (cnt8)
  );

  sat_accumulator #(.DATA_W(DATA_W), .ACC_W(6), .NUM_SAMPLES(NUM)) dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus6),
    .ovf_sticky (sticky6),
    .sample_cnt (cnt6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_ready);
    check({tag, "_valid8"}, bus8.out_valid, 1'b0);
    check({tag, "_valid6"}, bus6.out_valid, 1'b0);
    check({tag, "_ready8"}, bus8.in_ready, exp_ready);
    check({tag, "_ready6"}, bus6.in_ready, exp_ready);
    check({tag, "_cnt8"}, cnt8, 0);
    check({tag, "_cnt6"}, cnt6, 0);
    check({tag, "_sum8"}, bus8.out_sum, 0);
    check({tag, "_sum6"}, bus6.out_sum, 0);
    check({tag, "_sat8"}, bus8.out_sat, 1'b0);
    check({tag, "_sat6"}, bus6.out_sat, 1'b0);
    check({tag, "_sticky8"}, sticky8, exp_sticky8);
    check({tag, "_sticky6"}, sticky6, exp_sticky6);
  endtask

  // Offer one pair, wait (bounded) for in_ready, and let it be accepted.
  task automatic offer(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int waited = 0;
    int exp_cnt;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    #1;
    while (!bus6.in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("accept_ready", bus6.in_ready, 1'b1);
    @(posedge clk);
    m_total += int'(a) + int'(b);
    m_cnt++;
    exp_cnt = m_cnt;
    if (m_cnt == NUM) begin
      sb.push_back(m_total);
      if (m_total > 255) exp_sticky8 = 1'b1;
      if (m_total > 63) exp_sticky6 = 1'b1;
      m_total = 0;
      m_cnt = 0;
    end
    @(negedge clk);
    #1;
    check("cnt8", cnt8, exp_cnt);
    check("cnt6", cnt6, exp_cnt);
    $display("pair a=%0d b=%0d accepted cnt=%0d", a, b, exp_cnt);
  endtask

  task automatic collect(input bit keep_valid);
    int waited = 0;
    int t;
    int e8;
    int e6;
    if (!keep_valid) in_valid = 1'b0;
    #1;
    while (!bus6.out_valid && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("out_valid8", bus8.out_valid, 1'b1);
    check("out_valid6", bus6.out_valid, 1'b1);
    check("done_ready", bus6.in_ready, 1'b0);
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      t = sb.pop_front();
      e8 = (t > 255) ? 255 : t;
      e6 = (t > 63) ? 63 : t;
      check("sum8", bus8.out_sum, e8);
      check("sat8", bus8.out_sat, t > 255);
      check("sum6", bus6.out_sum, e6);
      check("sat6", bus6.out_sat, t > 63);
      check("sticky8", sticky8, exp_sticky8);
      check("sticky6", sticky6, exp_sticky6);
      $display("result total=%0d sum8=%0d sum6=%0d sat6=%0b", t, bus8.out_sum, bus6.out_sum, bus6.out_sat);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("post_valid", bus6.out_valid, 1'b0);
    check("post_ready", bus6.in_ready, 1'b1);
    check("post_cnt", cnt6, 0);
  endtask

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = 4'($urandom_range(0, 15));
      in_b = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #1;
    check_idle("reset", 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_idle("release", 1'b1);

    // 2: normal batch, continuous valid
    offer(4'd3, 4'd4);
    offer(4'd15, 4'd15);
    offer(4'd1, 4'd0);
    offer(4'd0, 4'd0);
    check("latency_valid", bus8.out_valid, 1'b1);
    collect(1'b0);

    // 3: saturation on the 6-bit instance, then a clean batch
    for (int i = 0; i < 4; i++) offer(4'd15, 4'd15);
    collect(1'b0);
    for (int i = 0; i < 4; i++) offer(4'd1, 4'd1);
    collect(1'b0);

    // 4: backpressure with a pending pair
    for (int i = 0; i < 4; i++) offer(4'd2, 4'd3);
    in_a = 4'd5;
    in_b = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_valid", bus6.out_valid, 1'b1);
      check("bp_sum", bus6.out_sum, 20);
      check("bp_ready", bus6.in_ready, 1'b0);
      check("bp_cnt", cnt6, NUM);
    end
    collect(1'b1);
    offer(4'd5, 4'd5);
    offer(4'd0, 4'd1);
    offer(4'd2, 4'd2);
    offer(4'd1, 4'd1);
    collect(1'b0);

    // 5: clear mid-batch drops the partial batch and the sticky flag
    offer(4'd4, 4'd4);
    offer(4'd1, 4'd2);
    clear = 1'b1;
    in_valid = 1'b1;
    in_a = 4'd7;
    in_b = 4'd7;
    #1;
    check("clear_ready", bus6.in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    m_total = 0;
    m_cnt = 0;
    exp_sticky8 = 1'b0;
    exp_sticky6 = 1'b0;
    #1;
    check_idle("clear", 1'b1);
    offer(4'd1, 4'd2);
    offer(4'd3, 4'd4);
    offer(4'd5, 4'd6);
    offer(4'd7, 4'd8);
    collect(1'b0);

    // 6: asynchronous reset while a result is waiting
    for (int i = 0; i < 4; i++) offer(4'd6, 4'd7);
    in_valid = 1'b0;
    check("pre_rst_valid", bus6.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    m_total = 0;
    m_cnt = 0;
    exp_sticky8 = 1'b0;
    exp_sticky6 = 1'b0;
    check_idle("async_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", bus6.in_ready, 1'b1);
    for (int i = 0; i < 4; i++) offer(4'd2, 4'd2);
    collect(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
Name: sat_accumulator

Overview:
- Downstream consumer of a 4-bit operand-pair adder stage.
- Accepts operand pairs (a, b) over a valid/ready handshake and forms each pair sum at full width, so pair sums never wrap.
- Accumulates NUM_SAMPLES pair sums into a saturating accumulator, then presents the batch result over a valid/ready output handshake.
- Reports overflow explicitly: a per-result saturation flag and a sticky flag.

Parameters:
- DATA_W, 4, operand width of in_a/in_b.
- ACC_W, 8, accumulator and out_sum width; must be >= DATA_W+1.
- NUM_SAMPLES, 4, operand pairs per batch; must be >= 1.
- CNT_W, $clog2(NUM_SAMPLES+1), sample_cnt width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous clear of batch state and sticky flag
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair
- in_a  input  DATA_W  operand a
- in_b  input  DATA_W  operand b
- out_valid  output  1  batch result valid
- out_ready  input  1  consumer takes result
- out_sum  output  ACC_W  saturated batch sum
- out_sat  output  1  saturation occurred in this batch
- ovf_sticky  output  1  saturation occurred since last clear/reset
- sample_cnt  output  CNT_W  pairs accepted in current batch

Behaviour:
- Reset (rst_n=0, asynchronous): state=S_IDLE; acc=0; sample_cnt=0; out_sat=0; ovf_sticky=0. Consequently out_valid=0 and in_ready=0 while rst_n is low. Reset may assert at any cycle, including mid-batch or mid-output; the batch is discarded.
- Priority: rst_n, then clear, then handshake activity.
- clear=1 at a clock edge has the same effect as reset. Any pair offered in that cycle is not accepted.
- States (2-bit encoding): S_IDLE=2'b00, S_ACCUM=2'b01, S_DONE=2'b10. Encoding 2'b11 is illegal and returns to S_IDLE via default; the case statement is full.
- in_ready=1 in S_IDLE and S_ACCUM (when rst_n=1 and clear=0); in_ready=0 in S_DONE.
- out_valid=1 only in S_DONE, and is a registered output.
- Accept condition: in_valid && in_ready.
- Pair sum: zero-extended to DATA_W+1 bits; never wraps.
- Accumulate: temp = {1'b0,acc} + zero-extended pair sum, computed at ACC_W+1 bits.
  - If temp[ACC_W]=1: acc<=all ones, out_sat<=1, ovf_sticky<=1.
  - Otherwise: acc<=temp[ACC_W-1:0].
- Once saturated, acc stays at all ones for the remainder of the batch.
- S_IDLE on accept: acc<=pair sum; sample_cnt<=1. Next state is S_DONE if NUM_SAMPLES==1, else S_ACCUM.
- S_ACCUM on accept: accumulate; sample_cnt++. Next state is S_DONE when sample_cnt reaches NUM_SAMPLES, else stay.
- No accept: state, acc and sample_cnt hold.
- Latency: out_valid rises on the edge that accepts the NUM_SAMPLES-th pair, i.e. it is visible the cycle after that handshake.
- S_DONE: out_sum=acc and out_sat are held stable while out_ready=0.
- S_DONE with out_ready=1: transfer completes → S_IDLE; acc<=0, sample_cnt<=0, out_sat<=0. ovf_sticky is kept.
- No simultaneous accept and output transfer: in_ready=0 in S_DONE.
- Every reg is assigned in every branch; no latches; single driver per signal.

Decomposition:
- Package sat_acc_pkg holds:
  - the state encoding localparams S_IDLE, S_ACCUM, S_DONE;
  - a state_t 2-bit typedef.
- Sub-module sat_add: combinational, parameterised ACC_W; inputs acc and addend; outputs the saturated sum and a sat flag. It is instantiated once and holds all overflow arithmetic.

Test Plan:
1. Reset: drive rst_n=0 for 3 cycles with random inputs → out_valid=0, in_ready=0, out_sum=0, out_sat=0, ovf_sticky=0, sample_cnt=0. Release rst_n → in_ready=1 on the next cycle.
2. Normal batch: pairs (3,4), (15,15), (1,0), (0,0) with in_valid continuous → out_valid=1 the cycle after the 4th accept; out_sum=8'h26 (38); out_sat=0; with out_ready=1 → S_IDLE, in_ready=1.
3. Saturation (ACC_W=6): four pairs (15,15) → out_sum=6'h3F, out_sat=1, ovf_sticky=1. Next batch (1,1)×4 → out_sum=8, out_sat=0, ovf_sticky still 1.
4. Backpressure: hold out_ready=0 for 5 cycles in S_DONE while in_valid=1 → out_valid and out_sum stable, in_ready=0, no pair consumed. Raise out_ready → one transfer, then the next pair is accepted.
5. Clear mid-batch: after 2 accepts, pulse clear with in_valid=1 → sample_cnt=0, acc=0, ovf_sticky=0, pair not counted. A full 4-pair batch then yields the correct sum.
6. Async reset mid-output: in S_DONE, drop rst_n between clock edges → out_valid falls immediately, before the next edge. After release, the batch (2,2)×4 → out_sum=16.
